// File: rtl/icache_tag_data_ram.sv
// Instruction-cache line store: tag/data RAM with per-line valid flops, 1-cycle lookup and a sequential flush sweep.
// Optional macro ICACHE_RAM_WR_BYPASS_EN selects write-first forwarding for same-index read/write; default is read-first.
module icache_tag_data_ram #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 138,
    parameter int TAG_W  = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_idx,
    input  logic [TAG_W-1:0]  i_rd_tag,
    output logic              o_rd_valid,
    output logic              o_rd_hit,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_idx,
    input  logic [TAG_W-1:0]  i_wr_tag,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_flush,
    output logic              o_busy
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE, FLUSH} state_e;

    state_e            state_q;
    logic              busy_q;
    logic [ADDR_W-1:0] flush_cnt_q;
    logic [DEPTH-1:0]  valid_q;

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [TAG_W-1:0]  tag_mem  [DEPTH];

    logic              rd_valid_q;
    logic              rd_hit_q;
    logic              rd_hit_d;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;
    logic              wr_ok;

    // A flush request in the same cycle takes priority and drops the refill.
    assign wr_ok = i_wr_en && (state_q == IDLE) && !i_flush;

    always_ff @(posedge i_clk) begin
        if (wr_ok) begin
            data_mem[i_wr_idx] <= i_wr_data;
            tag_mem[i_wr_idx]  <= i_wr_tag;
        end
    end

    always_comb begin
        rd_data_d = data_mem[i_rd_idx];
        rd_hit_d  = valid_q[i_rd_idx] && (tag_mem[i_rd_idx] == i_rd_tag);
`ifdef ICACHE_RAM_WR_BYPASS_EN
        if (wr_ok && (i_wr_idx == i_rd_idx)) begin
            rd_data_d = i_wr_data;
            rd_hit_d  = (i_wr_tag == i_rd_tag);
        end
`endif
        if (state_q == FLUSH) begin
            rd_hit_d = 1'b0;
        end
    end

    // Data and hit hold their last value when no lookup is issued.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= i_rd_req;
            if (i_rd_req) begin
                rd_hit_q  <= rd_hit_d;
                rd_data_q <= rd_data_d;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            flush_cnt_q <= '0;
            valid_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_flush) begin
                        state_q     <= FLUSH;
                        busy_q      <= 1'b1;
                        flush_cnt_q <= '0;
                    end else if (i_wr_en) begin
                        valid_q[i_wr_idx] <= 1'b1;
                    end
                end
                FLUSH: begin
                    valid_q[flush_cnt_q] <= 1'b0;
                    flush_cnt_q          <= flush_cnt_q + 1'b1;
                    if (flush_cnt_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_rd_valid = rd_valid_q;
    assign o_rd_hit   = rd_hit_q;
    assign o_rd_data  = rd_data_q;
    assign o_busy     = busy_q;

endmodule
